// File: rtl/cpu_defs.sv
// Shared constants for the fetch sequencer: default widths, opcodes and
// FSM state encodings.
package cpu_defs;

  localparam int AW_DEF = 6;
  localparam int IW_DEF = 12;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_JMP  = 4'h1;
  localparam opcode_t OP_BRZ  = 4'h2;
  localparam opcode_t OP_HALT = 4'hF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_DECODE = 3'd4;
  localparam logic [2:0] S_ISSUE  = 3'd5;
  localparam logic [2:0] S_UPDATE = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its program counter,
// instruction memory and datapath.
interface fetch_sequencer_if #(
  parameter int AW = 6,
  parameter int IW = 12
) ();

  logic [AW-1:0] pc_in;
  logic          pc_we;
  logic          pc_sel;
  logic [AW-1:0] pc_offset;
  logic [AW-1:0] imem_addr;
  logic          imem_re;
  logic [IW-1:0] imem_data;
  logic          zero_flag;
  logic          ex_valid;
  logic          ex_ready;
  logic [IW-1:0] ex_instr;

  modport master (
    input  pc_in, imem_data, zero_flag, ex_ready,
    output pc_we, pc_sel, pc_offset, imem_addr, imem_re, ex_valid, ex_instr
  );

  modport slave (
    output pc_in, imem_data, zero_flag, ex_ready,
    input  pc_we, pc_sel, pc_offset, imem_addr, imem_re, ex_valid, ex_instr
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational decode of opcode/imm/zero_flag into instruction class and
// the next-PC selection for the program counter.
module instr_decode
  import cpu_defs::*;
#(
  parameter int AW = AW_DEF
) (
  input  opcode_t       i_opcode,
  input  logic [5:0]    i_imm,
  input  logic          i_zero_flag,
  output logic          o_is_exec,
  output logic          o_is_halt,
  output logic          o_pc_sel,
  output logic [AW-1:0] o_pc_offset
);

  logic [AW-1:0] w_imm_ext;

  assign w_imm_ext = AW'($signed(i_imm));

  // Classify opcode and pick PC+1 or PC+1+imm
  always_comb begin
    o_is_exec   = 1'b0;
    o_is_halt   = 1'b0;
    o_pc_sel    = 1'b1;
    o_pc_offset = {AW{1'b0}};
    case (i_opcode)
      OP_NOP: o_pc_sel = 1'b1;
      OP_JMP: begin
        o_pc_sel    = 1'b0;
        o_pc_offset = w_imm_ext;
      end
      OP_BRZ: begin
        if (i_zero_flag) begin
          o_pc_sel    = 1'b0;
          o_pc_offset = w_imm_ext;
        end else begin
          o_pc_sel    = 1'b1;
        end
      end
      OP_HALT: o_is_halt = 1'b1;
      default: o_is_exec = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/issue sequencer steering an external program
// counter and instruction memory.
module fetch_sequencer
  import cpu_defs::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  fetch_sequencer_if.master  bus,
  output logic               halted
);

  logic [2:0]    r_state;
  logic [IW-1:0] r_ex_instr;
  logic          r_pc_sel;
  logic [AW-1:0] r_pc_offset;

  logic          w_is_exec;
  logic          w_is_halt;
  logic          w_pc_sel;
  logic [AW-1:0] w_pc_offset;

  instr_decode #(.AW(AW)) u_decode (
    .i_opcode   (r_ex_instr[11:8]),
    .i_imm      (r_ex_instr[5:0]),
    .i_zero_flag(bus.zero_flag),
    .o_is_exec  (w_is_exec),
    .o_is_halt  (w_is_halt),
    .o_pc_sel   (w_pc_sel),
    .o_pc_offset(w_pc_offset)
  );

  // State sequencing, instruction register and next-PC selection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ex_instr  <= {IW{1'b0}};
      r_pc_sel    <= 1'b0;
      r_pc_offset <= {AW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_state <= S_INIT;
        S_INIT:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_LATCH;
        S_LATCH: begin
          r_ex_instr <= bus.imem_data;
          r_state    <= S_DECODE;
        end
        S_DECODE: begin
          r_pc_sel    <= w_pc_sel;
          r_pc_offset <= w_pc_offset;
          if (w_is_halt) begin
            r_ex_instr <= {IW{1'b0}};
            r_state    <= S_HALT;
          end else if (w_is_exec) begin
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_UPDATE;
          end
        end
        S_ISSUE:  if (bus.ex_ready) r_state <= S_UPDATE;
        S_UPDATE: r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // The PC is written on the edge that leaves INIT/UPDATE, so address and
  // INIT offset must follow pc_in directly rather than a stale copy.
  assign bus.pc_we     = (r_state == S_INIT) || (r_state == S_UPDATE);
  assign bus.pc_sel    = (r_state == S_UPDATE) && r_pc_sel;
  assign bus.pc_offset = (r_state == S_INIT)   ? ~bus.pc_in :
                         (r_state == S_UPDATE) ? r_pc_offset : {AW{1'b0}};
  assign bus.imem_re   = (r_state == S_FETCH);
  assign bus.imem_addr = (r_state == S_FETCH) ? bus.pc_in : {AW{1'b0}};
  assign bus.ex_valid  = (r_state == S_ISSUE);
  assign bus.ex_instr  = r_ex_instr;
  assign halted        = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a program-counter and imem model.
module tb_fetch_sequencer;
  import cpu_defs::*;

  localparam int AW = 6;
  localparam int IW = 12;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic halted;

  fetch_sequencer_if #(.AW(AW), .IW(IW)) bus ();

  fetch_sequencer #(.AW(AW), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Program counter model (PC+1 or PC+1+offset), with a bench preload
  logic [AW-1:0] r_pc;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  always_ff @(posedge clk) begin
    if (pc_load) r_pc <= pc_load_val;
    else if (bus.pc_we) r_pc <= bus.pc_sel ? r_pc + 6'd1 : r_pc + 6'd1 + bus.pc_offset;
  end
  assign bus.pc_in = r_pc;

  // Instruction memory: data one cycle after the read strobe
  logic [IW-1:0] mem [0:63];
  always_ff @(posedge clk) begin
    if (bus.imem_re) bus.imem_data <= mem[bus.imem_addr];
  end

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] got [0:7];
  int ngot;
  int ndbl;

  typedef struct {
    logic [IW-1:0] instr;
    logic          zf;
    logic [AW-1:0] exp_pc;
    logic          exp_halt;
    int            exp_we;
  } vec_t;
  vec_t vecs [0:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_pc(input logic [AW-1:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    step();
    pc_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 12'h000;
  endtask

  // Record the PC after each of the next n writes, noting back-to-back writes
  task automatic collect(input int n, input int budget);
    logic prev;
    prev = 1'b0;
    ngot = 0;
    ndbl = 0;
    for (int c = 0; c < budget && ngot < n && !halted; c++) begin
      if (bus.pc_we) begin
        if (prev) ndbl++;
        prev = 1'b1;
        step();
        got[ngot] = r_pc;
        ngot++;
      end else begin
        prev = 1'b0;
        step();
      end
    end
  endtask

  initial begin
    int n;
    int bad_instr;
    bit found;
    rst = 1'b1; start = 1'b0; pc_load = 1'b0; pc_load_val = 6'h00;
    bus.zero_flag = 1'b0; bus.ex_ready = 1'b0;
    clear_mem();

    vecs[0] = '{12'h000, 1'b0, 6'h11, 1'b0, 3};
    vecs[1] = '{12'h2FE, 1'b1, 6'h0F, 1'b0, 3};
    vecs[2] = '{12'h2FE, 1'b0, 6'h11, 1'b0, 3};
    vecs[3] = '{12'h105, 1'b0, 6'h16, 1'b0, 3};
    vecs[4] = '{12'h13F, 1'b0, 6'h10, 1'b0, 3};
    vecs[5] = '{12'h5AB, 1'b0, 6'h11, 1'b0, 3};
    vecs[6] = '{12'h1C5, 1'b0, 6'h16, 1'b0, 3};
    vecs[7] = '{12'h120, 1'b0, 6'h31, 1'b0, 3};
    vecs[8] = '{12'hF00, 1'b0, 6'h10, 1'b1, 2};

    // Reset state
    do_reset();
    check("rst_ctrl", {bus.pc_we, bus.imem_re, bus.ex_valid, halted, bus.pc_sel}, 5'b00000);
    check("rst_pc_offset", bus.pc_offset, 6'h00);
    check("rst_ex_instr", bus.ex_instr, 12'h000);
    check("rst_imem_addr", bus.imem_addr, 6'h00);

    // Reset wins over start in the same cycle
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_prio_we", bus.pc_we, 1'b0);
    step();
    check("rst_prio_idle", {bus.pc_we, bus.imem_re}, 2'b00);

    // INIT from PC=0x2A, then NOP / JMP +5 sequence
    clear_mem();
    mem[0] = 12'h000;
    mem[1] = 12'h105;
    load_pc(6'h2A);
    pulse_start();
    check("init_we", bus.pc_we, 1'b1);
    check("init_sel", bus.pc_sel, 1'b0);
    check("init_offset", bus.pc_offset, 6'h15);
    step();
    check("init_pc_zero", r_pc, 6'h00);
    check("fetch0_re", bus.imem_re, 1'b1);
    check("fetch0_addr", bus.imem_addr, 6'h00);
    collect(2, 40);
    check("seq_writes", ngot, 2);
    check("seq_pc1", got[0], 6'h01);
    check("seq_pc2", got[1], 6'h07);
    check("seq_we_single", ndbl, 0);
    check("seq_fetch7", {bus.imem_re, bus.imem_addr}, {1'b1, 6'h07});

    // Table: mem[0] jumps to 0x10, instruction under test sits at 0x10
    bus.ex_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      clear_mem();
      mem[0] = 12'h10F;
      mem[6'h10] = vecs[v].instr;
      bus.zero_flag = vecs[v].zf;
      do_reset();
      pulse_start();
      collect(3, 40);
      check($sformatf("vec%0d_pc", v), r_pc, vecs[v].exp_pc);
      check($sformatf("vec%0d_halt", v), halted, vecs[v].exp_halt);
      check($sformatf("vec%0d_writes", v), ngot, vecs[v].exp_we);
    end
    bus.zero_flag = 1'b0;

    // EXEC stall: ready low for 3 cycles, early ready before valid ignored
    clear_mem();
    mem[0] = 12'h5AB;
    do_reset();
    bus.ex_ready = 1'b1;
    pulse_start();
    n = 0;
    bad_instr = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.ex_valid) begin
        n++;
        if (bus.ex_instr !== 12'h5AB) bad_instr++;
        bus.ex_ready = (n >= 4);
      end else if (n > 0) begin
        break;
      end
      step();
    end
    bus.ex_ready = 1'b0;
    check("exec_valid_cycles", n, 4);
    check("exec_instr_stable", bad_instr, 0);
    check("exec_update_we", {bus.pc_we, bus.pc_sel}, 2'b11);
    step();
    check("exec_pc", r_pc, 6'h01);

    // Wrap 0x3F -> 0x01, then HALT ignores start
    clear_mem();
    mem[0] = 12'h13E;
    mem[6'h3F] = 12'h101;
    mem[1] = 12'hF00;
    do_reset();
    pulse_start();
    collect(3, 40);
    check("wrap_writes", ngot, 3);
    check("wrap_pc_a", got[1], 6'h3F);
    check("wrap_pc_b", got[2], 6'h01);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (halted) found = 1'b1;
      else step();
    end
    check("halt_reached", found, 1'b1);
    check("halt_outputs", {bus.pc_we, bus.imem_re, bus.ex_valid, bus.pc_sel}, 4'b0000);
    check("halt_ex_instr", bus.ex_instr, 12'h000);
    n = 0;
    for (int p = 0; p < 3; p++) begin
      pulse_start();
      if (bus.pc_we || bus.imem_re || !halted) n++;
      step();
      if (bus.pc_we || bus.imem_re || !halted) n++;
    end
    check("halt_start_ignored", n, 0);
    check("halt_pc_held", r_pc, 6'h01);

    // Reset during ISSUE abandons the instruction
    clear_mem();
    mem[0] = 12'h5AB;
    bus.ex_ready = 1'b0;
    do_reset();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.ex_valid) found = 1'b1;
      else step();
    end
    check("issue_reached", found, 1'b1);
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    step();
    check("issue_rst_valid", bus.ex_valid, 1'b0);
    check("issue_rst_we", bus.pc_we, 1'b0);
    rst = 1'b0;
    bus.ex_ready = 1'b0;
    step();
    step();
    check("issue_rst_pc", r_pc, 6'h00);
    check("issue_rst_idle", {bus.imem_re, bus.ex_valid, bus.pc_we}, 3'b000);
    check("issue_rst_instr", bus.ex_instr, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
